// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: a circular FIFO with a show-ahead read port.
// Optional same-cycle empty-queue bypass is enabled by defining INST_QUEUE_BYPASS_EN.
package inst_queue_pkg;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [1:0]  pred_state;
    logic [7:0]  br_pattern;
    logic [7:0]  ghr;
    logic [31:0] btb_npc;
  } iq_struct_t;
endpackage

module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = $bits(iq_struct_t),
  parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enqueue,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  full,
  input  logic                  dequeue,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  empty,
  input  logic                  flush,
  input  logic                  redirect,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  overflow_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic                  state_empty;
  logic                  state_full;
  logic                  clear;
  logic                  bypass_use;
  logic                  enq_ok;
  logic                  deq_ok;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  assign state_empty = (head == tail);
  assign state_full  = (head[AW-1:0] == tail[AW-1:0]) && (head[AW] != tail[AW]);
  assign clear       = flush | redirect;
  assign full        = state_full;
  assign count       = CNT_WIDTH'(tail - head);

`ifdef INST_QUEUE_BYPASS_EN
  logic bypass_hit;
  // An empty queue forwards the incoming packet; a same-cycle dequeue swallows it.
  assign bypass_hit = state_empty & enqueue & ~clear;
  assign bypass_use = bypass_hit & dequeue;
  assign empty      = state_empty & ~bypass_hit;
  assign rdata      = bypass_hit ? wdata : mem[head[AW-1:0]];
`else
  assign bypass_use = 1'b0;
  assign empty      = state_empty;
  assign rdata      = mem[head[AW-1:0]];
`endif

  assign enq_ok = enqueue & ~state_full & ~bypass_use;
  assign deq_ok = dequeue & ~state_empty;

  always_ff @(posedge clk) begin
    if (enq_ok && !clear)
      mem[tail[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
    end else if (clear) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (enq_ok)
        tail <= tail + PW'(1);
      if (deq_ok)
        head <= head + PW'(1);
    end
  end

  // Sticky protocol error: fetch pushed into a full queue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      overflow_err <= 1'b0;
    else if (enqueue && state_full)
      overflow_err <= 1'b1;
  end

endmodule

// File: tb/tb_inst_queue.sv
// Directed scoreboard bench for inst_queue; bypass steps run only when INST_QUEUE_BYPASS_EN is defined.
module tb_inst_queue;
  import inst_queue_pkg::*;

  localparam int DEPTH = 16;
  localparam int DW    = $bits(iq_struct_t);
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enqueue = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic          full;
  logic          dequeue = 1'b0;
  logic [DW-1:0] rdata;
  logic          empty;
  logic          flush = 1'b0;
  logic          redirect = 1'b0;
  logic [CW-1:0] count;
  logic          overflow_err;

  int compared   = 0;
  int mismatched = 0;
  iq_struct_t sb[$];
  logic exp_ovf = 1'b0;
  logic [31:0] next_pc;

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .enqueue(enqueue), .wdata(wdata), .full(full),
    .dequeue(dequeue), .rdata(rdata), .empty(empty), .flush(flush),
    .redirect(redirect), .count(count), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  function automatic iq_struct_t make_pkt(input logic [31:0] pc);
    iq_struct_t p;
    p.inst       = pc ^ 32'hA5A5_0000;
    p.pc         = pc;
    p.pred_state = pc[3:2];
    p.br_pattern = pc[11:4];
    p.ghr        = ~pc[9:2];
    p.btb_npc    = pc + 32'd4;
    return p;
  endfunction

  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check_output({tag, ".empty"}, 128'(empty), 128'(sb.size() == 0));
    check_output({tag, ".full"}, 128'(full), 128'(sb.size() == DEPTH));
    check_output({tag, ".count"}, 128'(count), 128'(sb.size()));
    check_output({tag, ".ovf"}, 128'(overflow_err), 128'(exp_ovf));
    if (sb.size() != 0)
      check_output({tag, ".head"}, 128'(rdata), 128'(sb[0]));
  endtask

  // One clock of stimulus; the scoreboard is updated with the expected effect of the edge.
  task automatic apply_stimulus(input string tag, input logic enq, input logic deq,
                                input logic fl, input logic rd, input logic [31:0] pc);
    iq_struct_t pkt;
    iq_struct_t exp_pkt;
    bit was_full;
    bit consumed;
    pkt = make_pkt(pc);
    @(negedge clk);
    enqueue = enq; dequeue = deq; flush = fl; redirect = rd; wdata = pkt;
    #1;
    was_full = (sb.size() == DEPTH);
    consumed = 1'b0;
`ifdef INST_QUEUE_BYPASS_EN
    if (sb.size() == 0 && enq && !fl && !rd) begin
      check_output({tag, ".byp_empty"}, 128'(empty), 128'(0));
      check_output({tag, ".byp_rdata"}, 128'(rdata), 128'(pkt));
      consumed = deq;
    end
`endif
    if (deq && sb.size() != 0) begin
      exp_pkt = sb.pop_front();
      check_output({tag, ".deq_rdata"}, 128'(rdata), 128'(exp_pkt));
    end
    if (enq && was_full)
      exp_ovf = 1'b1;
    if (fl || rd)
      sb.delete();
    else if (enq && !was_full && !consumed)
      sb.push_back(pkt);
    @(posedge clk);
    #1;
    enqueue = 1'b0; dequeue = 1'b0; flush = 1'b0; redirect = 1'b0;
    #1;
    check_state(tag);
  endtask

  initial begin
    $display("[TB] inst_queue bench start");
    #2;
    check_state("reset");
    @(negedge clk);
    rst = 1'b1;

    // Fill to full, overflow once, then drain in order.
    for (int i = 0; i < 16; i++)
      apply_stimulus("fill", 1'b1, 1'b0, 1'b0, 1'b0, 32'h1000 + 32'(i) * 4);
    apply_stimulus("overflow", 1'b1, 1'b0, 1'b0, 1'b0, 32'h1040);
    for (int i = 0; i < 16; i++)
      apply_stimulus("drain", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    apply_stimulus("deq_empty", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);

    // Wrap-around of the pointer index.
    next_pc = 32'h5000;
    for (int i = 0; i < 12; i++) begin
      apply_stimulus("wrap_fill1", 1'b1, 1'b0, 1'b0, 1'b0, next_pc);
      next_pc += 4;
    end
    for (int i = 0; i < 12; i++)
      apply_stimulus("wrap_drain", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 12; i++) begin
      apply_stimulus("wrap_fill2", 1'b1, 1'b0, 1'b0, 1'b0, next_pc);
      next_pc += 4;
    end
    for (int i = 0; i < 7; i++)
      apply_stimulus("to_five", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);

    // Simultaneous enqueue and dequeue keep occupancy constant.
    for (int i = 0; i < 20; i++) begin
      apply_stimulus("simul", 1'b1, 1'b1, 1'b0, 1'b0, next_pc);
      next_pc += 4;
    end
    for (int i = 0; i < 11; i++) begin
      apply_stimulus("refill", 1'b1, 1'b0, 1'b0, 1'b0, next_pc);
      next_pc += 4;
    end
    apply_stimulus("simul_full", 1'b1, 1'b1, 1'b0, 1'b0, next_pc);
    next_pc += 4;

    // Redirect with concurrent dequeue and enqueue drops everything.
    for (int i = 0; i < 9; i++)
      apply_stimulus("to_six", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    apply_stimulus("redirect", 1'b1, 1'b1, 1'b0, 1'b1, 32'h6000);
    apply_stimulus("post_redir", 1'b1, 1'b0, 1'b0, 1'b0, 32'h2000);
    apply_stimulus("flush_one", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    apply_stimulus("post_flush", 1'b1, 1'b0, 1'b0, 1'b0, 32'h2000);

    // Asynchronous reset in the middle of a cycle.
    for (int i = 0; i < 8; i++) begin
      apply_stimulus("to_nine", 1'b1, 1'b0, 1'b0, 1'b0, next_pc);
      next_pc += 4;
    end
    @(negedge clk);
    #3;
    rst = 1'b0;
    #1;
    sb.delete();
    exp_ovf = 1'b0;
    check_state("async_rst");
    @(negedge clk);
    rst = 1'b1;
    apply_stimulus("after_rst", 1'b1, 1'b0, 1'b0, 1'b0, 32'h7000);
    apply_stimulus("after_rst_drain", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);

`ifdef INST_QUEUE_BYPASS_EN
    apply_stimulus("bypass", 1'b1, 1'b1, 1'b0, 1'b0, 32'h3000);
    @(negedge clk);
    enqueue = 1'b1; dequeue = 1'b1; flush = 1'b1; wdata = make_pkt(32'h3000);
    #1;
    check_output("bypass_flush.empty", 128'(empty), 128'(1));
    @(posedge clk);
    #1;
    enqueue = 1'b0; dequeue = 1'b0; flush = 1'b0;
    #1;
    check_state("bypass_flush");
    apply_stimulus("bypass_write", 1'b1, 1'b0, 1'b0, 1'b0, 32'h3004);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
